flash_read_ctrl: RTL and testbench
==================================

FLASH_READ_CTRL -- requirements
Module: flash_read_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 16: cycles flash_rp_n held low after reset release before the first command.
REQ-002 Parameter CMD_CYCLES, default 4: cycles flash_we_n held low for the read-array command write.
REQ-003 Parameter WAIT_CYCLES, default 8: cycles from flash_oe_n low to data capture; this is the read access time.
REQ-004 Parameter READY_CYCLES, default 2: cycles the ready output is held high per completed read.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 read_ctrl  input  1  read request; each toggle (either edge) is one request.
REQ-008 addr  input  22 [22:1]  word address of the request, sampled when the request is accepted.
REQ-009 flash_ready  output  1  completion strobe; a rising edge means flash_data is valid.
REQ-010 flash_data  output  16  last word read, held until the next capture.
REQ-011 fl_addr  output  22 [22:1]  flash address pins.
REQ-012 fl_data  inout  16  flash data pins; driven only during the command write, high-Z otherwise.
REQ-013 fl_ce_n, fl_oe_n, fl_we_n, fl_rp_n  output  1 each  active-low flash strobes.
REQ-014 fl_byte_n, fl_vpen  output  1 each  fl_byte_n tied to 1 (16-bit mode); fl_vpen tied to 0 (write-protect).

Function
REQ-015 The state machine SHALL have the states RST_WAIT, CMD_SET, CMD_HOLD, IDLE, RD_SETUP, RD_WAIT, RD_LATCH and RDY.
REQ-016 RST_WAIT SHALL hold fl_rp_n=0 and count RESET_CYCLES; at terminal count fl_rp_n goes to 1 and the machine moves to CMD_SET.
REQ-017 CMD_SET SHALL drive fl_ce_n=0, fl_data=16'h00FF and fl_addr=0, with fl_we_n=1; it lasts 1 cycle, then moves to CMD_HOLD.
REQ-018 CMD_HOLD SHALL drive fl_we_n=0 for CMD_CYCLES with data still driven.
- On exit, fl_we_n returns to 1 while data is still driven for 1 cycle (hold time).
- fl_data is then released, fl_ce_n=1, and the machine moves to IDLE.
REQ-019 A register served SHALL track the last accepted read_ctrl level; a request is pending whenever read_ctrl != served.
REQ-020 In IDLE with a pending request, the block SHALL:
- latch addr into fl_addr;
- set served to read_ctrl;
- move to RD_SETUP.
REQ-021 Toggles of read_ctrl in any other state SHALL NOT be lost; they are served on the next IDLE visit. A net-even number of toggles made while busy produces no extra read.
REQ-022 RD_SETUP SHALL drive fl_ce_n=0 for 1 cycle, then move to RD_WAIT.
REQ-023 RD_WAIT SHALL drive fl_ce_n=0 and fl_oe_n=0 and count WAIT_CYCLES.
REQ-024 RD_LATCH SHALL capture fl_data into flash_data, keep the strobes asserted for that cycle, then deassert both and move to RDY.
REQ-025 RDY SHALL hold flash_ready=1 for READY_CYCLES, then return to IDLE with flash_ready=0. The minimum latency from request acceptance to the flash_ready rising edge is WAIT_CYCLES+2 cycles.
REQ-026 flash_data SHALL be stable from the flash_ready rising edge until the next RD_LATCH.
REQ-027 Counters SHALL be sized for their parameter, reload on state entry, and never wrap inside a state.
REQ-028 A request arriving during RST_WAIT, CMD_SET or CMD_HOLD SHALL be served after initialisation completes.
REQ-029 fl_oe_n and fl_we_n SHALL never be low in the same cycle. fl_data SHALL never be driven while fl_oe_n=0.

Reset
REQ-030 While rst=0 the block SHALL force the following immediately, without waiting for clk:
- state=RST_WAIT, counters cleared;
- fl_rp_n=0, fl_ce_n=fl_oe_n=fl_we_n=1, fl_data high-Z, fl_addr=0;
- flash_ready=0, flash_data=0;
- served=read_ctrl.
REQ-031 Reset asserted mid-read SHALL abort the read with no flash_ready pulse. After release the full initialisation sequence (REQ-016..018) repeats.

Verification
REQ-032 Release rst -> fl_rp_n low for 16 cycles; then fl_we_n low for 4 cycles with fl_data=00FF; then IDLE with fl_data high-Z.
REQ-033 Toggle read_ctrl with addr=22'h000123 and the flash model returning 16'hBEEF -> fl_addr=123; fl_oe_n low 9 cycles; flash_ready high 2 cycles; flash_data=BEEF.
REQ-034 Toggle read_ctrl twice during one read -> no second read. Toggle three times -> exactly one additional read starts on return to IDLE.
REQ-035 Toggle read_ctrl during RST_WAIT -> the read starts in the first IDLE cycle after the command write.
REQ-036 Assert rst during RD_WAIT -> strobes deassert and flash_ready=0 in the same cycle, no capture; the init sequence repeats after release.
REQ-037 Checker throughout all tests: fl_oe_n and fl_we_n are never low together, and fl_data is never driven while fl_oe_n=0.

Source files
------------

// File: rtl/flash_read_ctrl.sv
// Read-array controller for a 16-bit parallel NOR flash.
// Toggle-handshake requests, fixed-cycle access timing.
module flash_read_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int CMD_CYCLES   = 4,
  parameter int WAIT_CYCLES  = 8,
  parameter int READY_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_ctrl,
  input  logic [22:1] addr,
  output logic        flash_ready,
  output logic [15:0] flash_data,
  output logic [22:1] fl_addr,
  inout  wire  [15:0] fl_data,
  output logic        fl_ce_n,
  output logic        fl_oe_n,
  output logic        fl_we_n,
  output logic        fl_rp_n,
  output logic        fl_byte_n,
  output logic        fl_vpen
);

  typedef enum logic [2:0] {
    RST_WAIT,
    CMD_SET,
    CMD_HOLD,
    IDLE,
    RD_SETUP,
    RD_WAIT,
    RD_LATCH,
    RDY
  } state_t;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // CMD_HOLD runs one extra cycle for data hold after fl_we_n rises
  localparam int MAXC = max2(max2(RESET_CYCLES, CMD_CYCLES + 1),
                             max2(WAIT_CYCLES, READY_CYCLES));
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_TC = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] CMD_TC = CW'(CMD_CYCLES);
  localparam logic [CW-1:0] WT_TC  = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] RDY_TC = CW'(READY_CYCLES - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          served;
  logic          accept;
  logic          drive;

  assign fl_byte_n = 1'b1;
  assign fl_vpen   = 1'b0;
  assign fl_data   = drive ? 16'h00FF : 16'hzzzz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RST_WAIT;
      cnt        <= '0;
      served     <= read_ctrl;
      fl_addr    <= '0;
      flash_data <= '0;
    end else begin
      state <= state_next;
      if (state_next != state || state == IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
      if (accept) begin
        served  <= read_ctrl;
        fl_addr <= addr;
      end
      if (state == RD_LATCH)
        flash_data <= fl_data;
    end
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    drive       = 1'b0;
    fl_rp_n     = 1'b1;
    fl_ce_n     = 1'b1;
    fl_oe_n     = 1'b1;
    fl_we_n     = 1'b1;
    flash_ready = 1'b0;
    unique case (state)
      RST_WAIT: begin
        fl_rp_n = 1'b0;
        if (cnt == RST_TC) state_next = CMD_SET;
      end
      CMD_SET: begin
        fl_ce_n    = 1'b0;
        drive      = 1'b1;
        state_next = CMD_HOLD;
      end
      CMD_HOLD: begin
        fl_ce_n = 1'b0;
        drive   = 1'b1;
        fl_we_n = (cnt >= CMD_TC);
        if (cnt == CMD_TC) state_next = IDLE;
      end
      IDLE: begin
        if (read_ctrl != served) begin
          accept     = 1'b1;
          state_next = RD_SETUP;
        end
      end
      RD_SETUP: begin
        fl_ce_n    = 1'b0;
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        fl_ce_n = 1'b0;
        fl_oe_n = 1'b0;
        if (cnt == WT_TC) state_next = RD_LATCH;
      end
      RD_LATCH: begin
        fl_ce_n    = 1'b0;
        fl_oe_n    = 1'b0;
        state_next = RDY;
      end
      RDY: begin
        flash_ready = 1'b1;
        if (cnt == RDY_TC) state_next = IDLE;
      end
      default: state_next = RST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Scoreboard bench for flash_read_ctrl.
// Flash model answers reads from a small fixed table.
module tb_flash_read_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_ctrl;
  logic [22:1] addr;
  logic        flash_ready;
  logic [15:0] flash_data;
  logic [22:1] fl_addr;
  wire  [15:0] fl_data;
  logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rp_n;
  logic        fl_byte_n, fl_vpen;
  logic [15:0] model_word;

  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int oe_run = 0;
  int rdy_run = 0;
  logic prev_rdy = 1'b0;
  logic [15:0] held;
  logic [37:0] sb[$];

  always #5 clk = ~clk;

  flash_read_ctrl dut (
    .clk(clk), .rst(rst), .read_ctrl(read_ctrl),
    .addr(addr), .flash_ready(flash_ready),
    .flash_data(flash_data), .fl_addr(fl_addr),
    .fl_data(fl_data), .fl_ce_n(fl_ce_n),
    .fl_oe_n(fl_oe_n), .fl_we_n(fl_we_n),
    .fl_rp_n(fl_rp_n), .fl_byte_n(fl_byte_n),
    .fl_vpen(fl_vpen)
  );

  always_comb begin
    model_word = 16'hDEAD;
    case (fl_addr)
      22'h000123: model_word = 16'hBEEF;
      22'h3FFFFF: model_word = 16'h1234;
      22'h000000: model_word = 16'hC0DE;
      22'h2AAAAA: model_word = 16'h5A5A;
      22'h155555: model_word = 16'h7E57;
      22'h000321: model_word = 16'h0321;
      22'h000456: model_word = 16'h4567;
      22'h0ABCDE: model_word = 16'hABCD;
      default:    model_word = 16'hDEAD;
    endcase
  end

  assign fl_data = (!fl_oe_n && !fl_ce_n) ? model_word : 16'hzzzz;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("oe_we_overlap", {31'd0, !fl_oe_n && !fl_we_n}, 0);
    if (!fl_oe_n)
      check("read_bus", {16'd0, fl_data}, {16'd0, model_word});
    if (!rst) begin
      oe_run   = 0;
      rdy_run  = 0;
      prev_rdy = 1'b0;
    end else begin
      if (!fl_oe_n) oe_run++;
      else if (oe_run != 0) begin
        check("oe_width", oe_run, 9);
        oe_run = 0;
      end
      if (flash_ready && !prev_rdy) begin
        rdy_cnt++;
        held = flash_data;
        if (sb.size() == 0) check("unexpected_ready", 1, 0);
        else begin
          logic [37:0] e;
          e = sb.pop_front();
          check("rd_addr", {10'd0, fl_addr}, {10'd0, e[37:16]});
          check("rd_data", {16'd0, flash_data}, {16'd0, e[15:0]});
        end
      end
      if (flash_ready) begin
        rdy_run++;
        if (flash_data !== held)
          check("data_stable", {16'd0, flash_data}, {16'd0, held});
      end else if (rdy_run != 0) begin
        check("ready_width", rdy_run, 2);
        rdy_run = 0;
      end
      prev_rdy = flash_ready;
    end
  end

  task automatic request(input logic [22:1] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    read_ctrl = ~read_ctrl;
    sb.push_back({a, d});
  endtask

  task automatic wait_ready(input int n);
    int g = 0;
    while (rdy_cnt < n && g < 300) begin
      g++;
      @(negedge clk);
    end
    check("ready_timeout", {31'd0, rdy_cnt >= n}, 1);
  endtask

  task automatic wait_oe_low();
    int g = 0;
    while (fl_oe_n && g < 100) begin
      g++;
      @(negedge clk);
    end
    check("oe_timeout", {31'd0, fl_oe_n}, 0);
  endtask

  task automatic init_check(input int rp_exp);
    int n = 0;
    int g = 0;
    int bad = 0;
    while (!fl_rp_n && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rp_low", n, rp_exp);
    while (fl_we_n && g < 100) begin
      check("cmd_ce", {31'd0, fl_ce_n}, 0);
      g++;
      @(negedge clk);
    end
    check("cmd_setup", g, 1);
    n = 0;
    while (!fl_we_n && n < 100) begin
      n++;
      if (fl_data !== 16'h00FF) bad++;
      @(negedge clk);
    end
    check("we_low", n, 4);
    check("cmd_data", bad, 0);
    check("hold_ce", {31'd0, fl_ce_n}, 0);
    check("hold_data", {16'd0, fl_data}, 32'h00FF);
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_rp"}, {31'd0, fl_rp_n}, 0);
    check({tag, "_ce"}, {31'd0, fl_ce_n}, 1);
    check({tag, "_oe"}, {31'd0, fl_oe_n}, 1);
    check({tag, "_we"}, {31'd0, fl_we_n}, 1);
    check({tag, "_rdy"}, {31'd0, flash_ready}, 0);
    check({tag, "_data"}, {16'd0, flash_data}, 0);
    check({tag, "_addr"}, {10'd0, fl_addr}, 0);
  endtask

  initial begin
    rst = 1'b0;
    read_ctrl = 1'b0;
    addr = '0;
    repeat (3) @(negedge clk);
    #1 reset_state("rst0");
    read_ctrl = 1'b1;
    check("byte_n", {31'd0, fl_byte_n}, 1);
    check("vpen", {31'd0, fl_vpen}, 0);
    @(negedge clk);
    rst = 1'b1;
    init_check(16);
    @(negedge clk);
    check("idle_ce", {31'd0, fl_ce_n}, 1);
    repeat (5) @(negedge clk);
    check("no_spurious", rdy_cnt, 0);

    request(22'h000123, 16'hBEEF);
    wait_ready(1);
    request(22'h3FFFFF, 16'h1234);
    wait_ready(2);
    request(22'h000000, 16'hC0DE);
    wait_ready(3);

    request(22'h2AAAAA, 16'h5A5A);
    wait_oe_low();
    read_ctrl = ~read_ctrl;
    @(negedge clk);
    read_ctrl = ~read_ctrl;
    wait_ready(4);
    repeat (25) @(negedge clk);
    check("even_toggles", rdy_cnt, 4);

    request(22'h155555, 16'h7E57);
    wait_oe_low();
    addr = 22'h000321;
    sb.push_back({22'h000321, 16'h0321});
    for (int i = 0; i < 3; i++) begin
      read_ctrl = ~read_ctrl;
      @(negedge clk);
    end
    wait_ready(6);
    repeat (25) @(negedge clk);
    check("odd_toggles", rdy_cnt, 6);
    check("sb_empty", sb.size(), 0);

    request(22'h000456, 16'h4567);
    wait_oe_low();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_state("abort");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    init_check(16);
    repeat (30) @(negedge clk);
    check("abort_no_ready", rdy_cnt, 6);

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    addr = 22'h0ABCDE;
    read_ctrl = ~read_ctrl;
    sb.push_back({22'h0ABCDE, 16'hABCD});
    init_check(13);
    @(negedge clk);
    check("early_idle_ce", {31'd0, fl_ce_n}, 1);
    @(negedge clk);
    check("early_setup_ce", {31'd0, fl_ce_n}, 0);
    check("early_setup_oe", {31'd0, fl_oe_n}, 1);
    @(negedge clk);
    check("early_wait_oe", {31'd0, fl_oe_n}, 0);
    wait_ready(7);
    repeat (10) @(negedge clk);
    check("final_count", rdy_cnt, 7);
    check("final_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
